imp_var_std_unit: RTL and testbench
===================================

Name: imp_var_std_unit

Overview:
- Consumer at the far end of the mean/mean-square statistics path in the ImprovedAILN LayerNorm datapath.
- Captures the single-cycle done/data pulses from the E[x] unit and the Ex2 unit, in either order, and computes Var = E[x^2] − E[x]^2, clamped at zero.
- Computes std = floor(sqrt(Var)) with a bit-serial restoring square root.
- Presents Var and std to the normalization stage with a one-cycle done pulse.

Parameters:
- EX_W, 8, width of signed mean input E[x].
- EX2_W, 16, width of unsigned mean-square input E[x^2].
- STD_W, 8, width of std result; equals EX2_W/2, so one square-root iteration per result bit.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_Ex_done  input  1  one-cycle pulse; i_Ex valid this cycle
- i_Ex  input  EX_W  signed mean, sampled only when i_Ex_done=1
- i_Ex2_done  input  1  one-cycle pulse; i_Ex2 valid this cycle
- i_Ex2  input  EX2_W  unsigned mean square, sampled only when i_Ex2_done=1
- o_busy  output  1  high in VAR, SQRT and DONE states
- o_drop  output  1  sticky; set when any input pulse arrives while o_busy=1
- o_done  output  1  one-cycle result pulse
- o_var  output  EX2_W  variance; valid only while o_done=1, else 0
- o_std  output  STD_W  floor sqrt of variance; valid only while o_done=1, else 0

Behaviour:
- Reset (i_rst=1, asynchronous, any state): state=COLLECT; both captured-flags cleared; all data registers 0; o_busy, o_drop, o_done, o_var, o_std all 0. Reset mid-SQRT discards the computation.
- States: COLLECT → VAR → SQRT → DONE → COLLECT.
- COLLECT:
  - i_Ex_done latches i_Ex and sets have_ex; i_Ex2_done latches i_Ex2 and sets have_ex2.
  - A repeat pulse of the same kind before its partner arrives overwrites the latched value; last value wins. No drop flag in this case.
  - Both pulses in the same cycle are both captured.
  - Go to VAR on the edge where both flags become (or already are) set.
- VAR (1 cycle):
  - sq = |Ex|^2, computed from magnitude; 15 bits, maximum 16384 for Ex=−128.
  - diff = {0,Ex2} − sq, evaluated as a 17-bit signed value.
  - var_r = diff<0 ? 0 : diff[15:0].
  - Clear both captured-flags; init root=0, rem=0, iteration count=0.
- SQRT (STD_W cycles):
  - Restoring digit-by-digit square root, one result bit per cycle, MSB first.
  - Each cycle: shift the next 2 radicand bits into rem; trial = {root,2'b01}; if rem ≥ trial then rem −= trial and the result bit is 1, else the bit is 0.
  - Go to DONE after iteration STD_W−1.
- DONE (1 cycle): o_done=1, o_var=var_r, o_std=root; then COLLECT.
- Latency: completing pulse sampled at edge 0 → o_done high in cycle 10 (1 VAR + 8 SQRT + DONE) for default widths.
- Back-to-back: a new pulse pair may start arriving in the cycle after DONE. Pulses arriving in VAR/SQRT/DONE are ignored and set o_drop.
- Arithmetic is unsigned except the Ex magnitude and the diff sign test. No saturation is needed: var ≤ 65535, std ≤ 255.

Optional Feature:
- Macro: IMP_VAR_STD_ROUND_EN.
- Defined: DONE outputs root+1 when the final rem > root, i.e. round-to-nearest sqrt. Saturate at 2^STD_W−1; unreachable for legal inputs. Latency unchanged.
- Undefined: o_std is floor(sqrt(var)).

Test Plan:
- i_Ex=0 and i_Ex2=100 pulsed together at cycle 0 → o_done at cycle 10, o_var=100, o_std=10; o_var/o_std=0 in all other cycles.
- i_Ex2=5000 at cycle 0, i_Ex=−20 at cycle 3 → o_var=4600, o_std=67 (68 with IMP_VAR_STD_ROUND_EN); o_done at cycle 13.
- i_Ex=10, i_Ex2=90 → diff=−10 clamped: o_var=0, o_std=0.
- i_Ex=−128, i_Ex2=32768 → o_var=16384, o_std=128; then i_Ex=0, i_Ex2=65535 → o_var=65535, o_std=255 (floor and rounded).
- i_Ex=5 then i_Ex=3 then i_Ex2=25 → o_var=16, o_std=4, o_drop=0. An extra i_Ex2_done during SQRT → result unchanged, o_drop=1 until reset.
- Assert i_rst during SQRT iteration 4 → outputs 0 immediately. Next pair i_Ex=1, i_Ex2=50 → o_var=49, o_std=7.

Source files
------------

// File: rtl/imp_var_std_unit.sv
// Variance / standard-deviation unit: joins the E[x] and E[x^2] pulses, forms Var = E[x^2]-E[x]^2
// (clamped at 0) and std = sqrt(Var) bit-serially. Define IMP_VAR_STD_ROUND_EN for rounded std.
module imp_var_std_unit #(
    parameter int unsigned EX_W  = 8,
    parameter int unsigned EX2_W = 16,
    parameter int unsigned STD_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_Ex_done,
    input  logic [EX_W-1:0]  i_Ex,
    input  logic             i_Ex2_done,
    input  logic [EX2_W-1:0] i_Ex2,
    output logic             o_busy,
    output logic             o_drop,
    output logic             o_done,
    output logic [EX2_W-1:0] o_var,
    output logic [STD_W-1:0] o_std
);

    localparam int unsigned SQ_W   = 2 * EX_W;
    localparam int unsigned DIFF_W = EX2_W + 1;
    localparam int unsigned REM_W  = STD_W + 2;
    localparam int unsigned SH_W   = REM_W + 2;
    localparam int unsigned CNT_W  = (STD_W > 1) ? $clog2(STD_W) : 1;

    typedef enum logic [1:0] {
        StCollect,
        StVar,
        StSqrt,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               have_ex_q, have_ex_d;
    logic               have_ex2_q, have_ex2_d;
    logic [EX_W-1:0]    ex_q, ex_d;
    logic [EX2_W-1:0]   ex2_q, ex2_d;
    logic [EX2_W-1:0]   var_q, var_d;
    logic [EX2_W-1:0]   rad_q, rad_d;
    logic [STD_W-1:0]   root_q, root_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;

    logic [EX_W-1:0]    ex_mag;
    logic [SQ_W-1:0]    ex_sq;
    logic [DIFF_W-1:0]  diff;
    logic [EX2_W-1:0]   var_clamped;
    logic [SH_W-1:0]    rem_shift;
    logic [SH_W-1:0]    trial;
    logic               trial_ok;
    logic [STD_W-1:0]   std_res;
    logic               busy;

    // Magnitude of the signed mean; -2^(EX_W-1) maps to 2^(EX_W-1), which still fits unsigned.
    assign ex_mag      = ex_q[EX_W-1] ? (~ex_q + EX_W'(1)) : ex_q;
    assign ex_sq       = SQ_W'(ex_mag) * SQ_W'(ex_mag);
    assign diff        = {1'b0, ex2_q} - DIFF_W'(ex_sq);
    assign var_clamped = diff[DIFF_W-1] ? '0 : diff[EX2_W-1:0];

    // Restoring square root step: bring down two radicand bits, try subtracting 4*root+1.
    assign rem_shift = {rem_q, rad_q[EX2_W-1 -: 2]};
    assign trial     = {2'b00, root_q, 2'b01};
    assign trial_ok  = (rem_shift >= trial);

    assign busy = (state_q != StCollect);

`ifdef IMP_VAR_STD_ROUND_EN
    // Remainder above root means Var >= root^2 + root + 1, i.e. closer to root+1.
    always_comb begin
        std_res = root_q;
        if ((rem_q > REM_W'(root_q)) && (root_q != '1)) begin
            std_res = root_q + STD_W'(1);
        end
    end
`else
    assign std_res = root_q;
`endif

    always_comb begin
        state_d    = state_q;
        have_ex_d  = have_ex_q;
        have_ex2_d = have_ex2_q;
        ex_d       = ex_q;
        ex2_d      = ex2_q;
        var_d      = var_q;
        rad_d      = rad_q;
        root_d     = root_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q | (busy & (i_Ex_done | i_Ex2_done));

        unique case (state_q)
            StCollect: begin
                if (i_Ex_done) begin
                    ex_d      = i_Ex;
                    have_ex_d = 1'b1;
                end
                if (i_Ex2_done) begin
                    ex2_d      = i_Ex2;
                    have_ex2_d = 1'b1;
                end
                if (have_ex_d && have_ex2_d) begin
                    state_d = StVar;
                end
            end
            StVar: begin
                var_d      = var_clamped;
                rad_d      = var_clamped;
                root_d     = '0;
                rem_d      = '0;
                cnt_d      = '0;
                have_ex_d  = 1'b0;
                have_ex2_d = 1'b0;
                state_d    = StSqrt;
            end
            StSqrt: begin
                if (trial_ok) begin
                    rem_d  = REM_W'(rem_shift - trial);
                    root_d = {root_q[STD_W-2:0], 1'b1};
                end else begin
                    rem_d  = REM_W'(rem_shift);
                    root_d = {root_q[STD_W-2:0], 1'b0};
                end
                rad_d = rad_q << 2;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STD_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StCollect;
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StCollect;
            have_ex_q  <= 1'b0;
            have_ex2_q <= 1'b0;
            ex_q       <= '0;
            ex2_q      <= '0;
            var_q      <= '0;
            rad_q      <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            have_ex_q  <= have_ex_d;
            have_ex2_q <= have_ex2_d;
            ex_q       <= ex_d;
            ex2_q      <= ex2_d;
            var_q      <= var_d;
            rad_q      <= rad_d;
            root_q     <= root_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
        end
    end

    assign o_busy = busy;
    assign o_drop = drop_q;
    assign o_done = (state_q == StDone);
    assign o_var  = o_done ? var_q : '0;
    assign o_std  = o_done ? std_res : '0;

endmodule

// File: tb/tb_imp_var_std_unit.sv
// Scoreboard bench for imp_var_std_unit: directed pulse pairs, monitor checks results and latency.
module tb_imp_var_std_unit;

`ifdef IMP_VAR_STD_ROUND_EN
    localparam bit Rnd = 1'b1;
`else
    localparam bit Rnd = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_Ex_done;
    logic [7:0]  i_Ex;
    logic        i_Ex2_done;
    logic [15:0] i_Ex2;
    logic        o_busy;
    logic        o_drop;
    logic        o_done;
    logic [15:0] o_var;
    logic [7:0]  o_std;

    imp_var_std_unit #(
        .EX_W  (8),
        .EX2_W (16),
        .STD_W (8)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_Ex_done  (i_Ex_done),
        .i_Ex       (i_Ex),
        .i_Ex2_done (i_Ex2_done),
        .i_Ex2      (i_Ex2),
        .o_busy     (o_busy),
        .o_drop     (o_drop),
        .o_done     (o_done),
        .o_var      (o_var),
        .o_std      (o_std)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] v;
        logic [7:0]  s;
        int unsigned c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse; outputs must read zero otherwise.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got var=%0d std=%0d, expected no result",
                             o_var, o_std);
                end else begin
                    e = sb.pop_front();
                    chk("var", o_var, e.v);
                    chk("std", o_std, e.s);
                    chk("done_cycle", cyc, e.c);
                end
            end else begin
                chk("var_idle_zero", o_var, 0);
                chk("std_idle_zero", o_std, 0);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v, input logic [7:0] s);
        exp_t x;
        x.v = v;
        x.s = s;
        x.c = cyc + 10;
        sb.push_back(x);
    endtask

    task automatic send(input bit ed, input logic [7:0] ev, input bit e2d, input logic [15:0] e2v);
        i_Ex_done  = ed;
        i_Ex2_done = e2d;
        if (ed) i_Ex = ev;
        if (e2d) i_Ex2 = e2v;
        step();
        i_Ex_done  = 1'b0;
        i_Ex2_done = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        step();
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_busy"}, o_busy, 0);
        chk({name, "_done"}, o_done, 0);
        chk({name, "_var"}, o_var, 0);
        chk({name, "_std"}, o_std, 0);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_Ex_done  = 1'b0;
        i_Ex2_done = 1'b0;
        i_Ex       = '0;
        i_Ex2      = '0;
        #2;
        check_quiet("reset");
        chk("reset_drop", o_drop, 0);
        step();
        step();
        i_rst = 1'b0;
        step();

        // Both pulses together
        push(16'd100, 8'd10);
        send(1, 8'd0, 1, 16'd100);
        chk("var_state_busy", o_busy, 1);
        wait_idle();

        // Ex2 first, Ex three cycles later
        send(0, 8'd0, 1, 16'd5000);
        step();
        step();
        push(16'd4600, Rnd ? 8'd68 : 8'd67);
        send(1, 8'hEC, 0, 16'd0);
        wait_idle();

        // Negative difference clamps to zero
        push(16'd0, 8'd0);
        send(1, 8'd10, 1, 16'd90);
        wait_idle();

        // Extremes
        push(16'd16384, 8'd128);
        send(1, 8'h80, 1, 16'd32768);
        wait_idle();
        push(16'd65535, 8'd255);
        send(1, 8'd0, 1, 16'd65535);
        wait_idle();

        // Repeated Ex overwrites, then a stray Ex2 during SQRT is dropped
        send(1, 8'd5, 0, 16'd0);
        send(1, 8'd3, 0, 16'd0);
        push(16'd16, 8'd4);
        send(0, 8'd0, 1, 16'd25);
        chk("drop_before", o_drop, 0);
        step();
        step();
        step();
        send(0, 8'd0, 1, 16'd999);
        chk("drop_set", o_drop, 1);
        wait_idle();
        chk("drop_sticky", o_drop, 1);
        chk("idle_after_done", o_busy, 0);

        // Async reset in the middle of SQRT iteration 4
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("drop_cleared", o_drop, 0);
        send(1, 8'd1, 1, 16'd50);
        for (int i = 0; i < 5; i++) step();
        chk("sqrt_busy", o_busy, 1);
        #1;
        i_rst = 1'b1;
        #1;
        check_quiet("mid_sqrt_reset");
        step();
        i_rst = 1'b0;
        step();
        push(16'd49, 8'd7);
        send(1, 8'd1, 1, 16'd50);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
